l2_arbiter: RTL and testbench
=============================

Name: l2_arbiter

Overview:
- Shares the single next-level (L2) port between the instruction cache and the data cache.
- Accepts line-fill requests from both L1 caches, plus writeback requests from the data cache.
- Serialises requests with round-robin arbitration and runs a req/ready handshake to L2.
- Returns 512-bit lines to the owning cache and exports 32-bit fill/writeback counters to STATS.

Parameters:
ADDR_W, 32, width of byte address on all ports
LINE_W, 512, cache line width in bits

Ports:
clk  in  1  system clock, all state updates on rising edge
clear  in  1  asynchronous active-low reset
i_req  in  1  instruction cache line-fill request, held until i_ack
i_add  in  ADDR_W  instruction fill address
i_data  out  LINE_W  line returned to instruction cache
i_ack  out  1  one-cycle completion pulse to instruction cache
d_req  in  1  data cache request, held until d_ack
d_we  in  1  1 = writeback of d_wdata, 0 = line fill
d_add  in  ADDR_W  data request address
d_wdata  in  LINE_W  writeback line
d_data  out  LINE_W  line returned to data cache
d_ack  out  1  one-cycle completion pulse to data cache
l2_req  out  1  request to L2, held until l2_ready
l2_we  out  1  L2 write enable
l2_add  out  ADDR_W  L2 address
l2_wdata  out  LINE_W  L2 write data
l2_rdata  in  LINE_W  L2 read data, valid with l2_ready
l2_ready  in  1  L2 completion strobe
busy  out  1  high in any state other than IDLE
owner  out  1  0 = I granted, 1 = D granted; valid while busy
i_fills  out  32  count of completed I fills
d_fills  out  32  count of completed D fills
d_wbacks  out  32  count of completed D writebacks

Behaviour:
- States are IDLE, WAIT and RESP, encoded in 2 bits. The 4th encoding goes to IDLE.
- Reset (clear=0, asynchronous):
  - State goes to IDLE.
  - All outputs go to 0, including i_data, d_data, the counters and l2_req.
  - The round-robin pointer "last" is set to I, so D wins the first contention.
  - An in-flight L2 transaction is abandoned. No ack is issued.
- IDLE:
  - Requests are sampled on the rising edge.
  - Only one requester high: that requester is granted.
  - Both high: the requester other than "last" is granted.
  - On grant, latch owner, address, we (0 for I) and wdata into internal registers. Update "last". Go to WAIT.
  - No request: stay in IDLE.
- WAIT:
  - l2_req=1. l2_add, l2_we and l2_wdata are driven from the latched registers and are stable for the whole state.
  - On an edge with l2_ready=1:
    - For a read, capture l2_rdata into the owner's data output register (i_data or d_data).
    - Go to RESP. l2_req is 0 from the following cycle.
  - With no l2_ready, WAIT holds indefinitely. There is no timeout.
- RESP:
  - The owner's ack is 1 for exactly one cycle.
  - The data output holds the captured line from RESP onward, until the next fill to that cache.
  - A writeback leaves d_data unchanged.
  - Counters update on the edge leaving RESP: I fill → i_fills+1; D read → d_fills+1; D write → d_wbacks+1.
  - Counters wrap modulo 2^32.
  - Next state is IDLE.
- Latency: a request high in IDLE cycle 0 gives l2_req high in cycle 1. With l2_ready in cycle k≥1, ack is high in cycle k+1, and the next grant can be sampled in cycle k+2.
- Requester rule: req must be deasserted at the edge ending its ack cycle. A req still high in the following IDLE cycle is a new request.
- Ignored inputs:
  - Requests and their address/data are ignored outside IDLE, because the latched values are used.
  - l2_ready is ignored outside WAIT.
  - The non-owner's output lines never change during another's transaction.
- Fairness: under continuous contention grants alternate D, I, D, I, …, so neither cache starves.

Test Plan:
1. Reset then single I fill: i_req=1, i_add=0x0000_1040, L2 returns pattern A with l2_ready in cycle 3 → l2_req cycles 1–3, l2_add=0x1040, l2_we=0, i_ack in cycle 4, i_data=A, i_fills=1, d_* outputs unchanged.
2. Simultaneous i_req and d_req (read) after reset → D served first (l2_add=d_add), then I, then under continued contention D again; acks alternate. d_fills=2, i_fills=1 after three transactions.
3. D writeback: d_req=1, d_we=1, d_add=0x0000_8000, d_wdata=B → l2_we=1, l2_wdata=B during WAIT, d_ack one cycle, d_data unchanged, d_wbacks=1, d_fills=0.
4. Stretched L2: l2_ready withheld for 20 cycles; i_add changes and l2_ready pulses during IDLE beforehand → l2_add stays the latched value throughout, busy=1, no ack until l2_ready; the stray pulse in IDLE has no effect.
5. Reset mid-WAIT (clear=0 while l2_req=1) → l2_req and busy drop immediately. No ack or counter update. After release, a fresh d_req is served normally with D priority.
6. Counter wrap: preload or run so i_fills=0xFFFF_FFFF, complete one I fill → i_fills=0x0000_0000, other counters unchanged.

Source files
------------

// File: rtl/l2_arbiter.sv
// Round-robin arbiter sharing one L2 port between the I-cache and D-cache.
// Latches the granted request, runs the req/ready handshake, returns lines and counts completions.
module l2_arbiter #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned LINE_W = 512
) (
    input  logic              clk,
    input  logic              clear,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_add,
    output logic [LINE_W-1:0] i_data,
    output logic              i_ack,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_add,
    input  logic [LINE_W-1:0] d_wdata,
    output logic [LINE_W-1:0] d_data,
    output logic              d_ack,
    output logic              l2_req,
    output logic              l2_we,
    output logic [ADDR_W-1:0] l2_add,
    output logic [LINE_W-1:0] l2_wdata,
    input  logic [LINE_W-1:0] l2_rdata,
    input  logic              l2_ready,
    output logic              busy,
    output logic              owner,
    output logic [31:0]       i_fills,
    output logic [31:0]       d_fills,
    output logic [31:0]       d_wbacks
);

    localparam int unsigned CNT_W = 32;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_next_state;
    logic                w_grant;
    logic                w_grant_d;
    logic                w_done;
    logic                r_last;
    logic                r_owner;
    logic                r_we;
    logic [ADDR_W-1:0]   r_add;
    logic [LINE_W-1:0]   r_wdata;
    logic [LINE_W-1:0]   r_i_data;
    logic [LINE_W-1:0]   r_d_data;
    logic                r_i_ack;
    logic                r_d_ack;
    logic                r_l2_req;
    logic                r_busy;
    logic [CNT_W-1:0]    r_i_fills;
    logic [CNT_W-1:0]    r_d_fills;
    logic [CNT_W-1:0]    r_d_wbacks;

    // Next-state and grant decode; r_last = 1 means D was granted most recently.
    always_comb begin
        w_next_state = S_IDLE;
        w_grant      = 1'b0;
        w_grant_d    = 1'b0;
        w_done       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_req || d_req) begin
                    w_grant      = 1'b1;
                    w_grant_d    = d_req && (!i_req || !r_last);
                    w_next_state = S_WAIT;
                end
            end
            S_WAIT: begin
                w_done       = l2_ready;
                w_next_state = l2_ready ? S_RESP : S_WAIT;
            end
            S_RESP:  w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge clear) begin
        if (!clear) begin
            r_state    <= S_IDLE;
            r_last     <= 1'b0;
            r_owner    <= 1'b0;
            r_we       <= 1'b0;
            r_add      <= '0;
            r_wdata    <= '0;
            r_i_data   <= '0;
            r_d_data   <= '0;
            r_i_ack    <= 1'b0;
            r_d_ack    <= 1'b0;
            r_l2_req   <= 1'b0;
            r_busy     <= 1'b0;
            r_i_fills  <= '0;
            r_d_fills  <= '0;
            r_d_wbacks <= '0;
        end else begin
            r_state  <= w_next_state;
            r_busy   <= (w_next_state != S_IDLE);
            r_l2_req <= (w_next_state == S_WAIT);
            r_i_ack  <= w_done && !r_owner;
            r_d_ack  <= w_done && r_owner;
            if (w_grant) begin
                r_owner <= w_grant_d;
                r_last  <= w_grant_d;
                r_add   <= w_grant_d ? d_add : i_add;
                r_we    <= w_grant_d && d_we;
                r_wdata <= w_grant_d ? d_wdata : '0;
            end
            if (w_done && !r_we) begin
                if (r_owner) r_d_data <= l2_rdata;
                else         r_i_data <= l2_rdata;
            end
            // Completion counters advance on the edge leaving RESP.
            if (r_state == S_RESP) begin
                if (!r_owner)  r_i_fills  <= r_i_fills + CNT_W'(1);
                else if (r_we) r_d_wbacks <= r_d_wbacks + CNT_W'(1);
                else           r_d_fills  <= r_d_fills + CNT_W'(1);
            end
        end
    end

    assign i_data   = r_i_data;
    assign d_data   = r_d_data;
    assign i_ack    = r_i_ack;
    assign d_ack    = r_d_ack;
    assign l2_req   = r_l2_req;
    assign l2_we    = r_we;
    assign l2_add   = r_add;
    assign l2_wdata = r_wdata;
    assign busy     = r_busy;
    assign owner    = r_owner;
    assign i_fills  = r_i_fills;
    assign d_fills  = r_d_fills;
    assign d_wbacks = r_d_wbacks;

endmodule

// File: tb/tb_l2_arbiter.sv
// Bench for l2_arbiter: directed scenarios plus randomized transactions checked
// against a transaction-level model (round-robin pointer, counters, returned lines).
module tb_l2_arbiter;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned LINE_W = 512;

    logic              clk;
    logic              clear;
    logic              i_req;
    logic [ADDR_W-1:0] i_add;
    logic [LINE_W-1:0] i_data;
    logic              i_ack;
    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_add;
    logic [LINE_W-1:0] d_wdata;
    logic [LINE_W-1:0] d_data;
    logic              d_ack;
    logic              l2_req;
    logic              l2_we;
    logic [ADDR_W-1:0] l2_add;
    logic [LINE_W-1:0] l2_wdata;
    logic [LINE_W-1:0] l2_rdata;
    logic              l2_ready;
    logic              busy;
    logic              owner;
    logic [31:0]       i_fills;
    logic [31:0]       d_fills;
    logic [31:0]       d_wbacks;

    int vectors;
    int miscompares;

    // Reference model state
    bit                m_last;
    logic [LINE_W-1:0] m_i_data;
    logic [LINE_W-1:0] m_d_data;
    logic [31:0]       m_i_fills;
    logic [31:0]       m_d_fills;
    logic [31:0]       m_d_wbacks;

    l2_arbiter #(.ADDR_W(ADDR_W), .LINE_W(LINE_W)) dut (
        .clk(clk), .clear(clear),
        .i_req(i_req), .i_add(i_add), .i_data(i_data), .i_ack(i_ack),
        .d_req(d_req), .d_we(d_we), .d_add(d_add), .d_wdata(d_wdata),
        .d_data(d_data), .d_ack(d_ack),
        .l2_req(l2_req), .l2_we(l2_we), .l2_add(l2_add), .l2_wdata(l2_wdata),
        .l2_rdata(l2_rdata), .l2_ready(l2_ready),
        .busy(busy), .owner(owner),
        .i_fills(i_fills), .d_fills(d_fills), .d_wbacks(d_wbacks)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk1(input string tag, input logic obs, input logic exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chkl(input string tag, input logic [LINE_W-1:0] obs, input logic [LINE_W-1:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [LINE_W-1:0] rnd_line();
        logic [LINE_W-1:0] l;
        for (int w = 0; w < 16; w++) l[w*32 +: 32] = $urandom;
        return l;
    endfunction

    task automatic model_reset();
        m_last     = 1'b0;
        m_i_data   = '0;
        m_d_data   = '0;
        m_i_fills  = '0;
        m_d_fills  = '0;
        m_d_wbacks = '0;
    endtask

    task automatic check_counters(input string tag);
        chk32({tag, ".i_fills"},  i_fills,  m_i_fills);
        chk32({tag, ".d_fills"},  d_fills,  m_d_fills);
        chk32({tag, ".d_wbacks"}, d_wbacks, m_d_wbacks);
    endtask

    task automatic drop_inputs();
        i_req = 1'b0; d_req = 1'b0; d_we = 1'b0; l2_ready = 1'b0;
    endtask

    // Called at a mid-cycle point of an IDLE cycle; returns at the next IDLE cycle.
    task automatic reset_dut();
        drop_inputs();
        clear = 1'b0;
        model_reset();
        @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
    endtask

    // One complete arbitration round: requests raised in IDLE, L2 answers after lat cycles.
    task automatic txn(input bit ir, input bit dr, input bit dwe,
                       input logic [ADDR_W-1:0] ia, input logic [ADDR_W-1:0] da,
                       input logic [LINE_W-1:0] dwd, input logic [LINE_W-1:0] rd,
                       input int lat);
        bit                wd;
        bit                ewe;
        logic [ADDR_W-1:0] ea;
        wd  = dr && (!ir || !m_last);
        ea  = wd ? da : ia;
        ewe = wd && dwe;
        i_req = ir; d_req = dr; d_we = dwe;
        i_add = ia; d_add = da; d_wdata = dwd;
        l2_ready = 1'b0;
        for (int c = 1; c <= lat; c++) begin
            @(negedge clk);
            chk1("wait.l2_req", l2_req, 1'b1);
            chk1("wait.busy", busy, 1'b1);
            chk1("wait.owner", owner, wd);
            chk32("wait.l2_add", l2_add, ea);
            chk1("wait.l2_we", l2_we, ewe);
            if (ewe) chkl("wait.l2_wdata", l2_wdata, dwd);
            chk1("wait.i_ack", i_ack, 1'b0);
            chk1("wait.d_ack", d_ack, 1'b0);
            // Requests and payload are don't-care outside IDLE.
            i_add = $urandom; d_add = $urandom; d_wdata = rnd_line(); d_we = ~d_we;
            l2_ready = (c == lat);
            l2_rdata = (c == lat) ? rd : rnd_line();
        end
        @(negedge clk);
        if (!ewe) begin
            if (wd) m_d_data = rd;
            else    m_i_data = rd;
        end
        chk1("resp.l2_req", l2_req, 1'b0);
        chk1("resp.busy", busy, 1'b1);
        chk1("resp.i_ack", i_ack, !wd);
        chk1("resp.d_ack", d_ack, wd);
        chkl("resp.i_data", i_data, m_i_data);
        chkl("resp.d_data", d_data, m_d_data);
        check_counters("resp");
        drop_inputs();
        m_last = wd;
        if (!wd)      m_i_fills  = m_i_fills + 32'd1;
        else if (ewe) m_d_wbacks = m_d_wbacks + 32'd1;
        else          m_d_fills  = m_d_fills + 32'd1;
        @(negedge clk);
        chk1("idle.busy", busy, 1'b0);
        chk1("idle.l2_req", l2_req, 1'b0);
        chk1("idle.i_ack", i_ack, 1'b0);
        chk1("idle.d_ack", d_ack, 1'b0);
        check_counters("idle");
    endtask

    initial begin
        logic [LINE_W-1:0] pat_a;
        logic [LINE_W-1:0] pat_b;
        bit ir;
        bit dr;
        vectors = 0;
        miscompares = 0;
        clear = 1'b0;
        i_req = 1'b0; i_add = '0; d_req = 1'b0; d_we = 1'b0; d_add = '0;
        d_wdata = '0; l2_rdata = '0; l2_ready = 1'b0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        chk1("rst.l2_req", l2_req, 1'b0);
        chk1("rst.busy", busy, 1'b0);
        chk1("rst.i_ack", i_ack, 1'b0);
        chk1("rst.d_ack", d_ack, 1'b0);
        chkl("rst.i_data", i_data, '0);
        chkl("rst.d_data", d_data, '0);
        check_counters("rst");
        clear = 1'b1;
        @(negedge clk);

        // Single I fill with ready in cycle 3
        pat_a = rnd_line();
        txn(1'b1, 1'b0, 1'b0, 32'h0000_1040, 32'h0, '0, pat_a, 3);
        chkl("t1.i_data", i_data, pat_a);
        chk32("t1.i_fills", i_fills, 32'd1);

        // Contention after reset: D, I, D
        reset_dut();
        txn(1'b1, 1'b1, 1'b0, 32'h0000_2000, 32'h0000_3000, '0, rnd_line(), 1);
        txn(1'b1, 1'b1, 1'b0, 32'h0000_2040, 32'h0000_3040, '0, rnd_line(), 2);
        txn(1'b1, 1'b1, 1'b0, 32'h0000_2080, 32'h0000_3080, '0, rnd_line(), 1);
        chk32("t2.d_fills", d_fills, 32'd2);
        chk32("t2.i_fills", i_fills, 32'd1);

        // D writeback
        reset_dut();
        pat_b = rnd_line();
        txn(1'b0, 1'b1, 1'b1, 32'h0, 32'h0000_8000, pat_b, rnd_line(), 2);
        chkl("t3.d_data", d_data, '0);
        chk32("t3.d_wbacks", d_wbacks, 32'd1);
        chk32("t3.d_fills", d_fills, 32'd0);

        // Stray l2_ready and address churn in IDLE, then stretched L2
        for (int s = 0; s < 3; s++) begin
            i_add = $urandom;
            l2_ready = 1'b1;
            l2_rdata = rnd_line();
            @(negedge clk);
            chk1("t4.stray.busy", busy, 1'b0);
            chk1("t4.stray.i_ack", i_ack, 1'b0);
            chkl("t4.stray.i_data", i_data, m_i_data);
            chkl("t4.stray.d_data", d_data, m_d_data);
        end
        l2_ready = 1'b0;
        txn(1'b1, 1'b0, 1'b0, 32'h0000_5500, 32'h0, '0, rnd_line(), 20);

        // Reset while in WAIT
        i_req = 1'b1; i_add = 32'h0000_7700;
        @(negedge clk);
        chk1("t5.pre.l2_req", l2_req, 1'b1);
        clear = 1'b0;
        #1;
        chk1("t5.l2_req", l2_req, 1'b0);
        chk1("t5.busy", busy, 1'b0);
        chk1("t5.i_ack", i_ack, 1'b0);
        model_reset();
        check_counters("t5");
        drop_inputs();
        @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        txn(1'b1, 1'b1, 1'b0, 32'h0000_7700, 32'h0000_7800, '0, rnd_line(), 2);

        // i_fills wrap
        force dut.r_i_fills = 32'hFFFF_FFFF;
        @(negedge clk);
        release dut.r_i_fills;
        m_i_fills = 32'hFFFF_FFFF;
        chk32("t6.preload", i_fills, 32'hFFFF_FFFF);
        txn(1'b1, 1'b0, 1'b0, 32'h0000_9000, 32'h0, '0, rnd_line(), 1);
        chk32("t6.wrap", i_fills, 32'h0000_0000);

        // Randomized rounds with idle gaps
        for (int n = 0; n < 60; n++) begin
            ir = 1'($urandom_range(0, 1));
            dr = 1'($urandom_range(0, 1));
            if (!ir && !dr) begin
                @(negedge clk);
                chk1("rnd.idle.busy", busy, 1'b0);
            end else begin
                txn(ir, dr, 1'($urandom_range(0, 1)), $urandom, $urandom,
                    rnd_line(), rnd_line(), int'($urandom_range(1, 6)));
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
